// File: rtl/core_pkg.sv
// Shared definitions for the core front end: fetch FSM states and
// instruction-width constants used by the fetch sequencer and its helpers.
package core_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection (JALR > JAL > taken branch > sequential).
// Reports the raw target's low-bit misalignment; the caller decides the policy.
module next_pc_calc
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]        instr_pc,
    input  logic signed [XLEN-1:0] imm,
    input  logic [XLEN-1:0]        rs1_val,
    input  logic                   branch_next,
    input  logic                   jump,
    input  logic                   jalr,
    output logic [XLEN-1:0]        next_pc,
    output logic                   misaligned
);

    logic [XLEN-1:0] target_jalr;
    logic [XLEN-1:0] target_rel;
    logic [XLEN-1:0] target_seq;

    // All sums wrap modulo 2^XLEN; the immediate is already sign-extended.
    assign target_jalr = (rs1_val + $unsigned(imm)) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign target_rel  = instr_pc + $unsigned(imm);
    assign target_seq  = instr_pc + XLEN'(INSTR_BYTES);

    always_comb begin
        next_pc = target_seq;
        if (jalr) begin
            next_pc = target_jalr;
        end else if (jump || branch_next) begin
            next_pc = target_rel;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and req/ack instruction fetch sequencer (FETCH/WAIT/HOLD/HALT).
// Optional feature: define MISALIGN_TRAP_EN to halt with misalign_err on a misaligned next PC.
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_next,
    input  logic                   jump,
    input  logic                   jalr,
    input  logic signed [XLEN-1:0] imm,
    input  logic [XLEN-1:0]        rs1_val,
    input  logic                   retire,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [XLEN-1:0]        instr_pc,
`ifdef MISALIGN_TRAP_EN
    output logic                   misalign_err,
`endif
    output logic [XLEN-1:0]        pc_plus4
);

    fetch_state_e    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            req_next;
    logic [XLEN-1:0] addr_next;
    logic [31:0]     instr_next;
    logic            valid_next;
    logic [XLEN-1:0] ipc_next;
    logic [XLEN-1:0] target;
    logic            misaligned;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc_calc (
        .instr_pc    (instr_pc),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .branch_next (branch_next),
        .jump        (jump),
        .jalr        (jalr),
        .next_pc     (target),
        .misaligned  (misaligned)
    );

    assign pc_plus4 = instr_pc + XLEN'(INSTR_BYTES);

`ifdef MISALIGN_TRAP_EN
    logic err_next;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        req_next   = imem_req;
        addr_next  = imem_addr;
        instr_next = instr;
        valid_next = instr_valid;
        ipc_next   = instr_pc;
`ifdef MISALIGN_TRAP_EN
        err_next   = misalign_err;
`endif
        case (state)
            FETCH: begin
                req_next   = 1'b1;
                addr_next  = pc;
                state_next = WAIT;
            end
            WAIT: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    ipc_next   = pc;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    valid_next = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        err_next   = 1'b1;
                        state_next = HALT;
                    end else begin
                        pc_next    = target;
                        state_next = FETCH;
                    end
`else
                    // Misaligned targets are silently word-aligned.
                    pc_next    = misaligned ? {target[XLEN-1:2], 2'b00} : target;
                    state_next = FETCH;
`endif
                end
            end
            HALT: begin
                req_next   = 1'b0;
                valid_next = 1'b0;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            instr_pc    <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            imem_req    <= req_next;
            imem_addr   <= addr_next;
            instr       <= instr_next;
            instr_valid <= valid_next;
            instr_pc    <= ipc_next;
`ifdef MISALIGN_TRAP_EN
            misalign_err <= err_next;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected fetches and
// presented instructions, a negedge monitor pops and compares them.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_next, jump, jalr, retire;
    logic [31:0] imm, rs1_val;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic        instr_valid;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    always #5 clk = ~clk;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_next (branch_next),
        .jump        (jump),
        .jalr        (jalr),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .retire      (retire),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
`ifdef MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .pc_plus4    (pc_plus4)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
        logic [31:0] plus4;
    } exp_t;

    logic [31:0] fetch_q[$];
    exp_t        instr_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          last_wait;
    bit          req_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Control inputs idle at "active" values so any use outside retire shows up.
    task automatic set_idle();
        branch_next = 1'b1;
        jump        = 1'b1;
        jalr        = 1'b1;
        imm         = 32'hDEAD_BEE1;
        rs1_val     = 32'h0000_0003;
        retire      = 1'b0;
    endtask

    task automatic wait_req();
        req_ok    = 1'b0;
        last_wait = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (imem_req) begin
                last_wait = i;
                req_ok    = 1'b1;
                break;
            end
        end
        if (!req_ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_instr(input logic [31:0] addr, input logic [31:0] word, input int delay,
                            input logic br, input logic j, input logic jr,
                            input logic [31:0] imm_v, input logic [31:0] rs1_v);
        exp_t e;
        e.word  = word;
        e.pc    = addr;
        e.plus4 = addr + 32'd4;
        fetch_q.push_back(addr);
        instr_q.push_back(e);
        wait_req();
        if (!req_ok) return;
        for (int i = 0; i < delay; i++) begin
            retire = 1'b1;
            @(negedge clk);
            check("req_held", {31'd0, imem_req}, 32'd1);
        end
        retire     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        check("valid_hold", {31'd0, instr_valid}, 32'd1);
        retire      = 1'b1;
        branch_next = br;
        jump        = j;
        jalr        = jr;
        imm         = imm_v;
        rs1_val     = rs1_v;
        @(negedge clk);
        set_idle();
        check("valid_drop", {31'd0, instr_valid}, 32'd0);
    endtask

    logic        mon_prev_req   = 1'b0;
    logic        mon_prev_valid = 1'b0;
    logic [31:0] mon_held_addr  = 32'd0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (imem_req && !mon_prev_req) begin
                if (fetch_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
                else check("fetch_addr", imem_addr, fetch_q.pop_front());
                mon_held_addr = imem_addr;
            end else if (imem_req && mon_prev_req) begin
                check("addr_stable", imem_addr, mon_held_addr);
            end
            if (instr_valid && !mon_prev_valid) begin
                if (instr_q.size() == 0) begin
                    check("unexpected_instr", instr, 32'hxxxx_xxxx);
                end else begin
                    e = instr_q.pop_front();
                    check("instr", instr, e.word);
                    check("instr_pc", instr_pc, e.pc);
                    check("pc_plus4", pc_plus4, e.plus4);
                end
            end
            mon_prev_req   = imem_req;
            mon_prev_valid = instr_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        set_idle();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0000_0100);
`ifdef MISALIGN_TRAP_EN
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
`endif
        rst = 1'b0;
        do_instr(32'h100, 32'h0050_0093, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("first_req_latency", last_wait, 32'd1);
        // 0x104 -> jump +0xFC -> 0x200
        do_instr(32'h104, 32'h0000_0013, 1, 1'b0, 1'b1, 1'b0, 32'h0000_00FC, 32'd0);
        do_instr(32'h200, 32'h1111_1111, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        do_instr(32'h1F8, 32'h2222_2222, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'd0);
        do_instr(32'h200, 32'h3333_3333, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
        do_instr(32'h204, 32'h4444_4444, 2, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_1001);
        do_instr(32'h1004, 32'h5555_5555, 0, 1'b0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
        do_instr(32'hFFFF_FFFC, 32'h6666_6666, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        do_instr(32'h0, 32'h7777_7777, 5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset in the third request cycle of the fetch at 0x4.
        fetch_q.push_back(32'h4);
        wait_req();
        @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_async_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("rst_drop_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b0;
        do_instr(32'h100, 32'h8888_8888, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0002, 32'd0);
        check("restart_latency", last_wait, 32'd1);
`ifdef MISALIGN_TRAP_EN
        check("trap_flag", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            retire   = 1'b1;
            imem_ack = 1'b1;
            @(negedge clk);
        end
        retire   = 1'b0;
        imem_ack = 1'b0;
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_flag_sticky", {31'd0, misalign_err}, 32'd1);
`else
        do_instr(32'h100, 32'h9999_9999, 0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        fetch_q.push_back(32'h104);
        repeat (3) @(negedge clk);
`endif
        repeat (2) @(negedge clk);
        check("fetch_q_empty", 32'(fetch_q.size()), 32'd0);
        check("instr_q_empty", 32'(instr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch sequencer for the monocycle core; the consumer of the branch comparator's `branch_next` decision.
- Holds the architectural PC and fetches each instruction over a req/ack handshake to instruction memory.
- Presents the fetched instruction to decode.
- On retire, computes the next PC from the branch/jump controls and returns to fetch.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- branch_next  in  1  branch-taken flag from the branch comparator; sampled only on retire.
- jump  in  1  JAL; sampled on retire.
- jalr  in  1  JALR; sampled on retire.
- imm  in  XLEN  sign-extended immediate of the current instruction.
- rs1_val  in  XLEN  rs1 operand, used for the JALR target.
- retire  in  1  core has finished the presented instruction.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched word.
- instr  out  32  instruction presented to decode.
- instr_valid  out  1  `instr` and `instr_pc` are valid.
- instr_pc  out  XLEN  PC of the presented instruction.
- pc_plus4  out  XLEN  `instr_pc + 4`, the link value for JAL/JALR.
- misalign_err  out  1  sticky misaligned-target flag; only present with the optional feature.

Behaviour:
- Reset values:
  - pc = RESET_PC.
  - state = FETCH.
  - imem_req = 0, instr_valid = 0, misalign_err = 0.
  - instr = 32'h0000_0013 (NOP).
  - instr_pc = RESET_PC.
- FSM states: FETCH, WAIT, HOLD, HALT.
- FETCH (one cycle):
  - imem_req <= 1, imem_addr <= pc.
  - Go to WAIT.
- WAIT:
  - imem_req and imem_addr stay stable until imem_ack.
  - On imem_ack: instr <= imem_rdata, instr_pc <= pc, instr_valid <= 1, imem_req <= 0; go to HOLD.
  - Ack on the same cycle as the FETCH→WAIT transition is accepted in WAIT, one cycle later. Memory must hold ack until seen, or respond no earlier than the first WAIT cycle.
- HOLD:
  - instr_valid = 1 until retire.
  - On retire: pc <= next_pc, instr_valid <= 0; go to FETCH.
- Minimum instruction period: 3 cycles (FETCH, WAIT with ack, HOLD with retire).
- next_pc priority, highest first:
  - jalr → (rs1_val + imm) & ~1.
  - jump → instr_pc + imm.
  - branch_next → instr_pc + imm.
  - otherwise → instr_pc + 4.
- Arithmetic is modulo 2^XLEN; wrap-around at 32'hFFFF_FFFC + 4 gives 0, with no flag.
- Ignored inputs:
  - imem_ack outside WAIT.
  - retire outside HOLD.
  - branch_next, jump and jalr outside the retire cycle. An `x` or unset branch_next in other cycles has no effect.
- Simultaneous jump and branch_next: jump wins (same target in any case).
- Reset asserted mid-WAIT: imem_req drops immediately (asynchronous) and any pending ack is discarded. After release, fetch restarts at RESET_PC on the first clock.
- HALT is reachable only with the optional feature. It is exited only by rst.

Optional Feature:
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - On retire, if next_pc[1:0] != 0: misalign_err <= 1, pc is left unchanged, state → HALT.
  - In HALT, imem_req = 0 and instr_valid = 0.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 and fetch continues.
  - The misalign_err port is absent.

Decomposition:
- Shared package `core_pkg` holds:
  - fetch state enum (FETCH, WAIT, HOLD, HALT);
  - NOP_INSTR = 32'h0000_0013;
  - INSTR_BYTES = 4.
- One combinational sub-module, `next_pc_calc`:
  - inputs: instr_pc, imm, rs1_val, branch_next, jump, jalr;
  - outputs: next_pc and misaligned.
  - It is reused by the future pipelined fetch.

Test Plan:
- Reset with RESET_PC = 32'h100 → imem_addr = 32'h100 and imem_req = 1 one cycle after release; ack with 32'h00500093 → instr matches, instr_pc = 32'h100, pc_plus4 = 32'h104.
- Retire with no controls → next fetch at 32'h104.
- instr_pc = 32'h200, imm = -8, branch_next = 1 at retire → next fetch at 32'h1F8. Same case with branch_next = 0 → 32'h204.
- jalr = 1, jump = 1, rs1_val = 32'h1001, imm = 4 at retire → fetch at 32'h1004 (jalr priority, bit 0 cleared).
- Ack delayed 5 cycles → imem_req and imem_addr stable throughout. Reset asserted in cycle 3 → imem_req = 0 in the same cycle, late ack ignored, restart at RESET_PC.
- With `MISALIGN_TRAP_EN`: jump with imm = 2 → misalign_err = 1, HALT, no further imem_req. Without the macro → fetch at instr_pc + 0 (low bits forced to zero).
